// File: rtl/mem_bus_arbiter_pkg.sv
// Shared state and owner codes for the memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int OWNER_W = 2;

    typedef enum logic [1:0] {
        ARB_S_IDLE  = 2'd0,
        ARB_S_ISSUE = 2'd1,
        ARB_S_WAIT  = 2'd2,
        ARB_S_DONE  = 2'd3
    } arb_state_e;

    typedef enum logic [OWNER_W-1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Request/ack and memory-port signal bundle around the arbiter.
// slave: the arbiter's view; master: requesters plus memory model.
interface mem_bus_arbiter_if
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic               cpu_req;
    logic               cpu_we;
    logic [ADDR_W-1:0]  cpu_addr;
    logic [DATA_W-1:0]  cpu_wdata;
    logic               cpu_ack;
    logic [DATA_W-1:0]  cpu_rdata;

    logic               dma_req;
    logic               dma_we;
    logic [ADDR_W-1:0]  dma_addr;
    logic [DATA_W-1:0]  dma_wdata;
    logic               dma_ack;
    logic [DATA_W-1:0]  dma_rdata;

    logic               mem_en;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  mem_rdata;

    logic [OWNER_W-1:0] owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_ack, cpu_rdata, dma_ack, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_ack, cpu_rdata, dma_ack, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, owner
    );

endinterface

// File: rtl/mem_arb_select.sv
// Grant decision for the memory bus arbiter.
// Optional build macro MEM_ARB_FAIRNESS_EN: a starvation counter forces a DMA
// grant after STARVE_LIMIT CPU grants made while the DMA was waiting.
// Without it the CPU has strict priority and the DMA can starve.
module mem_arb_select #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic decide,
    input  logic cpu_req,
    input  logic dma_req,
    output logic grant_cpu,
    output logic grant_dma
);

`ifdef MEM_ARB_FAIRNESS_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_q;
    logic             starved;

    assign starved = (starve_q >= CNT_W'(STARVE_LIMIT));

    // CPU wins a tie unless the DMA has already waited through STARVE_LIMIT CPU grants
    always_comb begin
        grant_dma = dma_req && (!cpu_req || starved);
        grant_cpu = cpu_req && !grant_dma;
    end

    // Count CPU grants taken over a waiting DMA; any DMA grant clears the count
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_q <= '0;
        end else if (decide) begin
            if (grant_dma) begin
                starve_q <= '0;
            end else if (grant_cpu && dma_req) begin
                starve_q <= starve_q + CNT_W'(1);
            end
        end
    end
`else
    logic unused_sel;

    assign unused_sel = clock ^ reset ^ decide;

    // Strict CPU priority
    always_comb begin
        grant_cpu = cpu_req;
        grant_dma = dma_req && !cpu_req;
    end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the CPU and a DMA master.
// One transaction at a time: IDLE (grant + latch) -> ISSUE (mem_en) ->
// WAIT (MEM_LATENCY cycles, read data captured on the last) -> DONE (ack).
// Optional build macro MEM_ARB_FAIRNESS_EN enables DMA anti-starvation
// inside mem_arb_select.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clock,
    input  logic               reset,
    mem_bus_arbiter_if.slave   bus
);

    // Counter holds MEM_LATENCY-1 down to 0
    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    arb_state_e        state_q;
    arb_state_e        state_d;
    owner_e            owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [LAT_W-1:0]  lat_cnt_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dma_rdata_q;

    logic decide;
    logic grant_cpu;
    logic grant_dma;
    logic lat_done;
    logic mem_en;
    logic cpu_ack;
    logic dma_ack;

    assign decide   = (state_q == ARB_S_IDLE);
    assign lat_done = (lat_cnt_q == '0);

    mem_arb_select #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_select (
        .clock     (clock),
        .reset     (reset),
        .decide    (decide),
        .cpu_req   (bus.cpu_req),
        .dma_req   (bus.dma_req),
        .grant_cpu (grant_cpu),
        .grant_dma (grant_dma)
    );

    // State register; async reset abandons any transaction in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ARB_S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the per-state strobes
    always_comb begin
        state_d = state_q;
        mem_en  = 1'b0;
        cpu_ack = 1'b0;
        dma_ack = 1'b0;
        unique case (state_q)
            ARB_S_IDLE: begin
                if (grant_cpu || grant_dma) begin
                    state_d = ARB_S_ISSUE;
                end
            end
            ARB_S_ISSUE: begin
                mem_en  = 1'b1;
                state_d = ARB_S_WAIT;
            end
            ARB_S_WAIT: begin
                if (lat_done) begin
                    state_d = ARB_S_DONE;
                end
            end
            ARB_S_DONE: begin
                cpu_ack = (owner_q == OWN_CPU);
                dma_ack = (owner_q == OWN_DMA);
                state_d = ARB_S_IDLE;
            end
            default: begin
                state_d = ARB_S_IDLE;
            end
        endcase
    end

    // Transaction latches, latency counter and per-requester read data
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner_q     <= OWN_NONE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            lat_cnt_q   <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            unique case (state_q)
                ARB_S_IDLE: begin
                    if (grant_cpu) begin
                        owner_q <= OWN_CPU;
                        we_q    <= bus.cpu_we;
                        addr_q  <= bus.cpu_addr;
                        wdata_q <= bus.cpu_wdata;
                    end else if (grant_dma) begin
                        owner_q <= OWN_DMA;
                        we_q    <= bus.dma_we;
                        addr_q  <= bus.dma_addr;
                        wdata_q <= bus.dma_wdata;
                    end
                end
                ARB_S_ISSUE: begin
                    lat_cnt_q <= LAT_W'(MEM_LATENCY - 1);
                end
                ARB_S_WAIT: begin
                    if (!lat_done) begin
                        lat_cnt_q <= lat_cnt_q - LAT_W'(1);
                    end else if (!we_q) begin
                        if (owner_q == OWN_CPU) begin
                            cpu_rdata_q <= bus.mem_rdata;
                        end else if (owner_q == OWN_DMA) begin
                            dma_rdata_q <= bus.mem_rdata;
                        end
                    end
                end
                ARB_S_DONE: begin
                    owner_q <= OWN_NONE;
                end
                default: begin
                    owner_q <= OWN_NONE;
                end
            endcase
        end
    end

    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_en & we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_ack   = cpu_ack;
    assign bus.dma_ack   = dma_ack;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dma_rdata = dma_rdata_q;
    assign bus.owner     = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter (MEM_LATENCY=2, STARVE_LIMIT=4).
// Honors MEM_ARB_FAIRNESS_EN the same way the design does.
module tb_mem_bus_arbiter;

    localparam int LAT   = 2;
    localparam int LIMIT = 4;
    localparam int SLOT  = LAT + 3;   // IDLE + ISSUE + WAIT*LAT + DONE
`ifdef MEM_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    mem_bus_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_bus_arbiter #(
        .ADDR_W       (16),
        .DATA_W       (16),
        .MEM_LATENCY  (LAT),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Memory model: writes on mem_en, read data valid LAT cycles after mem_en
    logic        poke_en = 1'b0;
    logic [15:0] poke_addr = '0;
    logic [15:0] poke_data = '0;
    logic [15:0] mem_arr [0:255];
    logic [15:0] rd_p1;

    always @(posedge clock) begin
        if (poke_en) mem_arr[poke_addr[7:0]] <= poke_data;
        else if (bus.mem_en && bus.mem_we) mem_arr[bus.mem_addr[7:0]] <= bus.mem_wdata;
        rd_p1 <= (bus.mem_en && !bus.mem_we) ? mem_arr[bus.mem_addr[7:0]] : 16'($urandom);
        bus.mem_rdata <= rd_p1;
    end

    // Reference state
    logic [15:0] ref_mem [0:255];
    logic [15:0] exp_crd, exp_drd;
    int          fair_cnt;
    logic        auto_drop;

    logic [63:0] rec_en, rec_we, rec_cack, rec_dack;
    logic [1:0]  rec_own [0:63];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_reqs();
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        poke_en = 1; poke_addr = a; poke_data = d;
        ref_mem[a[7:0]] = d;
        tick();
        poke_en = 0;
    endtask

    task automatic do_reset();
        clear_reqs();
        reset = 0;
        tick(); tick();
        reset = 1;
        exp_crd = '0; exp_drd = '0; fair_cnt = 0;
    endtask

    // Record n cycles starting now (index 0 = current cycle); requesters drop req after ack
    task automatic observe(input int n);
        logic cdrop, ddrop;
        rec_en = '0; rec_we = '0; rec_cack = '0; rec_dack = '0;
        for (int i = 0; i < 64; i++) rec_own[i] = '0;
        for (int i = 0; i < n; i++) begin
            rec_en[i]   = bus.mem_en;
            rec_we[i]   = bus.mem_we;
            rec_cack[i] = bus.cpu_ack;
            rec_dack[i] = bus.dma_ack;
            rec_own[i]  = bus.owner;
            cdrop = auto_drop && bus.cpu_ack;
            ddrop = auto_drop && bus.dma_ack;
            tick();
            if (cdrop) bus.cpu_req = 0;
            if (ddrop) bus.dma_req = 0;
        end
    endtask

    task automatic test_reset();
        logic [69:0] outs;
        for (int i = 0; i < 6; i++) begin
            bus.cpu_req = 1'($urandom); bus.cpu_we = 1'($urandom);
            bus.cpu_addr = 16'($urandom); bus.cpu_wdata = 16'($urandom);
            bus.dma_req = 1'($urandom); bus.dma_we = 1'($urandom);
            bus.dma_addr = 16'($urandom); bus.dma_wdata = 16'($urandom);
            tick();
            outs = {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.cpu_ack,
                    bus.dma_ack, bus.cpu_rdata, bus.dma_rdata, bus.owner};
            n_checks++;
            if (outs !== 70'd0) begin
                n_errors++;
                $display("FAIL reset_outputs cyc%0d: got %h expected 0", i, outs);
            end
        end
        clear_reqs();
        reset = 1;
        exp_crd = '0; exp_drd = '0; fair_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({bus.mem_en, bus.owner} !== 3'd0) begin
                n_errors++;
                $display("FAIL reset_release_idle: got en=%b owner=%0d expected 0/0", bus.mem_en, bus.owner);
            end
        end
    endtask

    task automatic test_cpu_read();
        logic bad;
        do_reset();
        poke(16'h0040, 16'hBEEF);
        bus.cpu_we = 0; bus.cpu_addr = 16'h0040; bus.cpu_wdata = 16'($urandom); bus.cpu_req = 1;
        auto_drop = 1;
        observe(8);
        exp_crd = 16'hBEEF;
        n_checks++;
        if (rec_en !== 64'h2) begin n_errors++; $display("FAIL read_mem_en: got %h expected %h", rec_en, 64'h2); end
        n_checks++;
        if (rec_we !== 64'h0) begin n_errors++; $display("FAIL read_mem_we: got %h expected 0", rec_we); end
        n_checks++;
        if (rec_cack !== (64'h1 << (LAT + 2))) begin n_errors++; $display("FAIL read_cpu_ack: got %h expected %h", rec_cack, 64'h1 << (LAT + 2)); end
        n_checks++;
        if (rec_dack !== 64'h0) begin n_errors++; $display("FAIL read_dma_ack: got %h expected 0", rec_dack); end
        bad = 0;
        for (int i = 0; i < 8; i++) if (rec_own[i] !== ((i >= 1 && i <= LAT + 2) ? 2'd1 : 2'd0)) bad = 1;
        n_checks++;
        if (bad) begin n_errors++; $display("FAIL read_owner: got %0d at cyc1 expected 1 during cycles 1..%0d", rec_own[1], LAT + 2); end
        n_checks++;
        if (bus.cpu_rdata !== exp_crd) begin n_errors++; $display("FAIL read_cpu_rdata: got %h expected %h", bus.cpu_rdata, exp_crd); end
        n_checks++;
        if (bus.dma_rdata !== 16'h0) begin n_errors++; $display("FAIL read_dma_rdata: got %h expected 0", bus.dma_rdata); end
        tick(); tick(); tick();
        n_checks++;
        if ({bus.cpu_rdata, bus.mem_addr} !== {exp_crd, 16'h0040}) begin
            n_errors++; $display("FAIL read_hold: got rdata=%h addr=%h expected %h/0040", bus.cpu_rdata, bus.mem_addr, exp_crd);
        end
    endtask

    task automatic test_priority();
        logic bad;
        logic [1:0] eo;
        poke(16'h0020, 16'hCAFE);
        bus.cpu_we = 1; bus.cpu_addr = 16'h0010; bus.cpu_wdata = 16'h1234; bus.cpu_req = 1;
        bus.dma_we = 0; bus.dma_addr = 16'h0020; bus.dma_wdata = 16'($urandom); bus.dma_req = 1;
        auto_drop = 1;
        observe(12);
        ref_mem[8'h10] = 16'h1234;
        exp_drd = 16'hCAFE;
        n_checks++;
        if (rec_en !== 64'h42) begin n_errors++; $display("FAIL prio_mem_en: got %h expected 42", rec_en); end
        n_checks++;
        if (rec_we !== 64'h2) begin n_errors++; $display("FAIL prio_mem_we: got %h expected 2", rec_we); end
        n_checks++;
        if (rec_cack !== 64'h10) begin n_errors++; $display("FAIL prio_cpu_ack: got %h expected 10", rec_cack); end
        n_checks++;
        if (rec_dack !== 64'h200) begin n_errors++; $display("FAIL prio_dma_ack: got %h expected 200", rec_dack); end
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            eo = (i >= 1 && i <= 4) ? 2'd1 : (i >= 6 && i <= 9) ? 2'd2 : 2'd0;
            if (rec_own[i] !== eo) bad = 1;
        end
        n_checks++;
        if (bad) begin n_errors++; $display("FAIL prio_owner: got %0d/%0d at cyc1/6 expected 1/2", rec_own[1], rec_own[6]); end
        n_checks++;
        if ({bus.cpu_rdata, bus.dma_rdata} !== {exp_crd, exp_drd}) begin
            n_errors++; $display("FAIL prio_rdata: got %h/%h expected %h/%h", bus.cpu_rdata, bus.dma_rdata, exp_crd, exp_drd);
        end
        // the CPU write must have reached memory
        bus.cpu_we = 0; bus.cpu_addr = 16'h0010; bus.cpu_req = 1;
        observe(7);
        exp_crd = ref_mem[8'h10];
        n_checks++;
        if (bus.cpu_rdata !== exp_crd) begin n_errors++; $display("FAIL prio_readback: got %h expected %h", bus.cpu_rdata, exp_crd); end
    endtask

    task automatic test_starvation();
        logic [63:0] ec, ed;
        int cnt;
        do_reset();
        ec = '0; ed = '0; cnt = 0;
        for (int s = 0; s < 10; s++) begin
            if (FAIR && cnt >= LIMIT) begin
                ed[SLOT * s + LAT + 2] = 1'b1; cnt = 0;
            end else begin
                ec[SLOT * s + LAT + 2] = 1'b1; cnt++;
            end
        end
        bus.cpu_we = 0; bus.cpu_addr = 16'h0040; bus.cpu_req = 1;
        bus.dma_we = 0; bus.dma_addr = 16'h0020; bus.dma_req = 1;
        auto_drop = 0;
        observe(SLOT * 10);
        clear_reqs();
        n_checks++;
        if (rec_cack !== ec) begin n_errors++; $display("FAIL starve_cpu_ack: got %h expected %h", rec_cack, ec); end
        n_checks++;
        if (rec_dack !== ed) begin n_errors++; $display("FAIL starve_dma_ack: got %h expected %h", rec_dack, ed); end
        n_checks++;
        if ($countones(rec_cack) != (FAIR ? 8 : 10)) begin
            n_errors++; $display("FAIL starve_cpu_count: got %0d expected %0d", $countones(rec_cack), FAIR ? 8 : 10);
        end
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.cpu_we = 0; bus.cpu_addr = 16'h0040; bus.cpu_req = 1;
        auto_drop = 1;
        tick(); tick();
        n_checks++;
        if (bus.owner !== 2'd1) begin n_errors++; $display("FAIL midrst_owner_before: got %0d expected 1", bus.owner); end
        #2 reset = 0;
        #1;
        n_checks++;
        if ({bus.mem_en, bus.owner, bus.cpu_ack} !== 4'd0) begin
            n_errors++; $display("FAIL midrst_immediate: got en=%b owner=%0d ack=%b expected 0", bus.mem_en, bus.owner, bus.cpu_ack);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({bus.cpu_ack, bus.cpu_rdata} !== 17'd0) begin
                n_errors++; $display("FAIL midrst_no_ack: got ack=%b rdata=%h expected 0", bus.cpu_ack, bus.cpu_rdata);
            end
        end
        reset = 1;
        observe(8);
        n_checks++;
        if ({rec_en, rec_cack} !== {64'h2, 64'h1 << (LAT + 2)}) begin
            n_errors++; $display("FAIL midrst_reissue: got en=%h ack=%h expected 2/%h", rec_en, rec_cack, 64'h1 << (LAT + 2));
        end
        n_checks++;
        if (bus.cpu_rdata !== ref_mem[8'h40]) begin n_errors++; $display("FAIL midrst_rdata: got %h expected %h", bus.cpu_rdata, ref_mem[8'h40]); end
    endtask

    task automatic test_drop_req();
        logic bad;
        do_reset();
        bus.cpu_we = 0; bus.cpu_addr = 16'h0040; bus.cpu_req = 1;
        auto_drop = 1;
        tick(); tick();
        bus.cpu_req = 0;
        observe(8);   // index 0 = cycle 2
        n_checks++;
        if (rec_cack !== (64'h1 << (LAT + 2 - 2))) begin n_errors++; $display("FAIL drop_ack: got %h expected %h", rec_cack, 64'h1 << LAT); end
        n_checks++;
        if (rec_en !== 64'h0) begin n_errors++; $display("FAIL drop_no_regrant: got mem_en %h expected 0", rec_en); end
        bad = 0;
        for (int i = 0; i < 8; i++) if (rec_own[i] !== ((i <= LAT) ? 2'd1 : 2'd0)) bad = 1;
        n_checks++;
        if (bad) begin n_errors++; $display("FAIL drop_owner: got %0d at cyc%0d expected 0", rec_own[LAT + 1], LAT + 3); end
        n_checks++;
        if (bus.cpu_rdata !== ref_mem[8'h40]) begin n_errors++; $display("FAIL drop_rdata: got %h expected %h", bus.cpu_rdata, ref_mem[8'h40]); end
    endtask

    task automatic test_random();
        logic [1:0]  mode;
        logic        cwe, dwe, c_pend, d_pend, pick_dma;
        logic [15:0] caddr, daddr, cwd, dwd;
        logic [63:0] e_en, e_we, e_c, e_d;
        int slot;
        do_reset();
        auto_drop = 1;
        for (int it = 0; it < 40; it++) begin
            mode = 2'($urandom_range(1, 3));
            cwe = 1'($urandom); dwe = 1'($urandom);
            caddr = 16'h0080 + 16'($urandom_range(0, 15));
            daddr = 16'h0080 + 16'($urandom_range(0, 15));
            cwd = 16'($urandom); dwd = 16'($urandom);
            bus.cpu_we = cwe; bus.cpu_addr = caddr; bus.cpu_wdata = cwd; bus.cpu_req = mode[0];
            bus.dma_we = dwe; bus.dma_addr = daddr; bus.dma_wdata = dwd; bus.dma_req = mode[1];
            // transaction-level model: grant order, ack slots, memory effects
            e_en = '0; e_we = '0; e_c = '0; e_d = '0;
            c_pend = mode[0]; d_pend = mode[1]; slot = 0;
            while (c_pend || d_pend) begin
                pick_dma = d_pend && (!c_pend || (FAIR && fair_cnt >= LIMIT));
                e_en[SLOT * slot + 1] = 1'b1;
                if (pick_dma) begin
                    fair_cnt = 0;
                    e_d[SLOT * slot + LAT + 2] = 1'b1;
                    e_we[SLOT * slot + 1] = dwe;
                    if (dwe) ref_mem[daddr[7:0]] = dwd; else exp_drd = ref_mem[daddr[7:0]];
                    d_pend = 0;
                end else begin
                    if (d_pend) fair_cnt++;
                    e_c[SLOT * slot + LAT + 2] = 1'b1;
                    e_we[SLOT * slot + 1] = cwe;
                    if (cwe) ref_mem[caddr[7:0]] = cwd; else exp_crd = ref_mem[caddr[7:0]];
                    c_pend = 0;
                end
                slot++;
            end
            observe(2 * SLOT + 2);
            n_checks++;
            if (rec_cack !== e_c) begin n_errors++; $display("FAIL rand%0d_cpu_ack: got %h expected %h", it, rec_cack, e_c); end
            n_checks++;
            if (rec_dack !== e_d) begin n_errors++; $display("FAIL rand%0d_dma_ack: got %h expected %h", it, rec_dack, e_d); end
            n_checks++;
            if (rec_en !== e_en) begin n_errors++; $display("FAIL rand%0d_mem_en: got %h expected %h", it, rec_en, e_en); end
            n_checks++;
            if (rec_we !== e_we) begin n_errors++; $display("FAIL rand%0d_mem_we: got %h expected %h", it, rec_we, e_we); end
            n_checks++;
            if (bus.cpu_rdata !== exp_crd) begin n_errors++; $display("FAIL rand%0d_cpu_rdata: got %h expected %h", it, bus.cpu_rdata, exp_crd); end
            n_checks++;
            if (bus.dma_rdata !== exp_drd) begin n_errors++; $display("FAIL rand%0d_dma_rdata: got %h expected %h", it, bus.dma_rdata, exp_drd); end
        end
    endtask

    initial begin
        clear_reqs();
        auto_drop = 1;
        exp_crd = '0; exp_drd = '0; fair_cnt = 0;
        #2 reset = 0;
        for (int i = 0; i < 256; i++) poke(16'(i), 16'(i * 16'h0101) ^ 16'h3C5A);
        test_reset();
        test_cpu_read();
        test_priority();
        test_starvation();
        test_reset_mid();
        test_drop_req();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
